// File: rtl/sp_core_pipe.sv
// Streaming-processor lane: register file, registered execute stage with bypass, req/ack memory port.
// Optional multiplier for op 12 is enabled by defining SP_CORE_PIPE_MUL_EN.
module sp_core_pipe #(
  parameter int CORE_ID = 0,
  parameter int N_CORES = 1,
  parameter int DATA_W  = 16,
  parameter int N_REGS  = 16,
  parameter int ADDR_W  = 16,
  localparam int REG_AW = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [REG_AW-1:0] x,
  input  logic [REG_AW-1:0] y,
  input  logic [REG_AW-1:0] z,
  input  logic [DATA_W-1:0] imm,
  input  logic [3:0]        aluc,
  input  logic [1:0]        s2,
  input  logic              reg_we,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              en,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              P,
  output logic              busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] MEM  = 2'd2;
  localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [1:0]        state;
  logic [DATA_W-1:0] regs [N_REGS];

  logic              vld_p1;
  logic              mem_p1, ld_p1, we_p1;
  logic [1:0]        s2_p1;
  logic [3:0]        op_p1;
  logic [REG_AW-1:0] x_p1;
  logic [DATA_W-1:0] imm_p1, b_p1, c_p1, s_p1;

  logic              fire, wb_en;
  logic [DATA_W-1:0] alu_y, wb_data, b_byp, c_byp, s_byp;

  function automatic logic [DATA_W-1:0] alu(input logic [3:0] op,
                                            input logic [DATA_W-1:0] b,
                                            input logic [DATA_W-1:0] c);
    logic [SH_W-1:0] sh;
    sh = c[SH_W-1:0];
    case (op)
      4'd0:    alu = b + c;
      4'd1:    alu = b - c;
      4'd2:    alu = b & c;
      4'd3:    alu = b | c;
      4'd4:    alu = b ^ c;
      4'd5:    alu = b << sh;
      4'd6:    alu = b >> sh;
      4'd9:    alu = b;
      4'd10:   alu = DATA_W'(CORE_ID);
      4'd11:   alu = DATA_W'(N_CORES);
`ifdef SP_CORE_PIPE_MUL_EN
      4'd12:   alu = b * c;
`else
`endif
      default: alu = '0;
    endcase
  endfunction

  assign busy        = (state != IDLE);
  assign issue_ready = (state == IDLE) || ((state == EXEC) && !(vld_p1 && mem_p1));
  assign fire        = issue_valid && issue_ready;
  assign alu_y       = alu(op_p1, b_p1, c_p1);

  // Single writeback port: an executing ALU op or a load completing on ack
  always_comb begin
    wb_en   = 1'b0;
    wb_data = '0;
    if ((state == EXEC) && vld_p1 && !mem_p1 && we_p1 && (s2_p1 != 2'd3)) begin
      wb_en   = 1'b1;
      wb_data = (s2_p1 == 2'd0) ? imm_p1 : (s2_p1 == 2'd2) ? alu_y : '0;
    end else if ((state == MEM) && mem_ack && ld_p1 && we_p1 && (s2_p1 == 2'd1)) begin
      wb_en   = 1'b1;
      wb_data = mem_rdata;
    end
  end

  assign b_byp = (wb_en && (x_p1 == y)) ? wb_data : regs[y];
  assign c_byp = (wb_en && (x_p1 == z)) ? wb_data : regs[z];
  assign s_byp = (wb_en && (x_p1 == x)) ? wb_data : regs[x];

  // p0 -> p1: decode and bypassed operands captured at accept
  always_ff @(posedge clk) begin
    if (fire) begin
      op_p1  <= aluc;
      s2_p1  <= s2;
      we_p1  <= reg_we;
      mem_p1 <= mem_rd | mem_wr;
      ld_p1  <= mem_rd & ~mem_wr;
      x_p1   <= x;
      imm_p1 <= imm;
      b_p1   <= b_byp;
      c_p1   <= c_byp;
      s_p1   <= s_byp;
    end
  end

  // p1 -> retire: writeback, predicate, memory request and FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      vld_p1    <= 1'b0;
      P         <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else begin
      if (wb_en) regs[x_p1] <= wb_data;
      if (fire) vld_p1 <= en;
      case (state)
        IDLE: if (fire) state <= EXEC;
        EXEC: begin
          if (vld_p1 && !mem_p1 && ((op_p1 == 4'd7) || (op_p1 == 4'd8)))
            P <= (op_p1 == 4'd7) ? (b_p1 < c_p1) : (b_p1 == c_p1);
          if (vld_p1 && mem_p1) begin
            state     <= MEM;
            mem_req   <= 1'b1;
            mem_we    <= ~ld_p1;
            mem_addr  <= ADDR_W'(b_p1);
            mem_wdata <= s_p1;
          end else begin
            state <= fire ? EXEC : IDLE;
          end
        end
        MEM: if (mem_ack) begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sp_core_pipe.sv
// Randomized self-checking bench for sp_core_pipe; registers are observed through store transactions.
module tb_sp_core_pipe;
  localparam int DW = 16;
  localparam int NR = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic          issue_ready;
  logic [3:0]    x, y, z;
  logic [DW-1:0] imm;
  logic [3:0]    aluc;
  logic [1:0]    s2;
  logic          reg_we, mem_rd, mem_wr, en;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          P, busy;

  always #5 clk = ~clk;

  sp_core_pipe #(.CORE_ID(3), .N_CORES(8), .DATA_W(DW), .N_REGS(NR), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .x(x), .y(y), .z(z), .imm(imm), .aluc(aluc), .s2(s2), .reg_we(reg_we),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .en(en), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .P(P), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: architectural registers and predicate, updated in program order
  logic [DW-1:0] mr [NR];
  logic          mp;

  function automatic logic [DW-1:0] model_alu(input logic [3:0] op, input logic [DW-1:0] b,
                                              input logic [DW-1:0] c);
    longint ub, uc, r;
    ub = b; uc = c; r = 0;
    case (op)
      4'd0:  r = ub + uc;
      4'd1:  r = ub - uc + 65536;
      4'd2:  r = ub & uc;
      4'd3:  r = ub | uc;
      4'd4:  r = ub ^ uc;
      4'd5:  r = ub << (uc % 16);
      4'd6:  r = ub >> (uc % 16);
      4'd9:  r = ub;
      4'd10: r = 3;
      4'd11: r = 8;
`ifdef SP_CORE_PIPE_MUL_EN
      4'd12: r = ub * uc;
`endif
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  task automatic model_apply(input logic [3:0] xi, yi, zi, input logic [DW-1:0] immi,
                             input logic [3:0] op, input logic [1:0] s2i,
                             input logic wei, rdi, wri, eni);
    logic [DW-1:0] b, c, res;
    if (!eni) return;
    b = mr[yi]; c = mr[zi];
    if (rdi || wri) begin
      if (!wri && wei && s2i == 2'd1) mr[xi] = mem_rdata;
    end else begin
      res = model_alu(op, b, c);
      if (op == 4'd7) mp = (b < c);
      if (op == 4'd8) mp = (b == c);
      if (wei && s2i != 2'd3) mr[xi] = (s2i == 2'd0) ? immi : (s2i == 2'd2) ? res : '0;
    end
  endtask

  // Memory responder: acks after ack_delay extra cycles, pulses stray acks while idle
  int            ack_delay = 0;
  int            rcnt = 0;
  int            txn_start = 0;
  int            last_cycles = 0;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_wdata;
  logic          f_we;

  always @(negedge clk) begin
    if (mem_req && !reset) begin
      if (rcnt == 0) begin
        txn_start++;
        f_addr = mem_addr; f_wdata = mem_wdata; f_we = mem_we;
      end else begin
        chk("addr_hold", mem_addr, f_addr);
        chk("wdata_hold", mem_wdata, f_wdata);
        chk("we_hold", mem_we, f_we);
      end
      chk("ready_in_mem", issue_ready, 0);
      rcnt++;
      if (rcnt > ack_delay) begin
        mem_ack = 1'b1; last_cycles = rcnt; rcnt = 0;
      end else begin
        mem_ack = 1'b0;
      end
    end else begin
      rcnt = 0;
      mem_ack = ($urandom_range(0, 3) == 0);
    end
  end

  task automatic issue(input logic [3:0] xi, yi, zi, input logic [DW-1:0] immi,
                       input logic [3:0] op, input logic [1:0] s2i,
                       input logic wei, rdi, wri, eni);
    int n = 0;
    x = xi; y = yi; z = zi; imm = immi; aluc = op; s2 = s2i;
    reg_we = wei; mem_rd = rdi; mem_wr = wri; en = eni; issue_valid = 1'b1;
    while (!issue_ready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("issue_timeout", 1, 0);
    model_apply(xi, yi, zi, immi, op, s2i, wei, rdi, wri, eni);
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("idle_timeout", 1, 0);
  endtask

  task automatic mem_op(input string tag, input logic [3:0] xi, yi, input logic is_load,
                        input logic wei, input logic [1:0] s2i, input logic eni,
                        input int dly, input logic [DW-1:0] rdv);
    int            t0;
    logic [DW-1:0] e_addr, e_wdata;
    wait_idle();
    ack_delay = dly; mem_rdata = rdv;
    e_addr = mr[yi]; e_wdata = mr[xi];
    t0 = txn_start;
    issue(xi, yi, 4'd0, 16'h0, 4'd0, s2i, wei, is_load, !is_load, eni);
    wait_idle();
    @(negedge clk);
    if (eni) begin
      chk({tag, "_txn"}, txn_start, t0 + 1);
      chk({tag, "_we"}, f_we, !is_load);
      chk({tag, "_addr"}, f_addr, e_addr);
      if (!is_load) chk({tag, "_wdata"}, f_wdata, e_wdata);
      chk({tag, "_cycles"}, last_cycles, dly + 1);
    end else begin
      chk({tag, "_noreq"}, txn_start, t0);
    end
  endtask

  task automatic read_reg(input logic [3:0] r);
    mem_op($sformatf("rd_r%0d", r), r, 4'd0, 1'b0, 1'b0, 2'd3, 1'b1, $urandom_range(0, 2), 16'h0);
  endtask

  task automatic mov_imm(input logic [3:0] r, input logic [DW-1:0] v);
    issue(r, 4'd0, 4'd0, v, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) mr[i] = '0;
    mp = 1'b0;
    reset = 1'b1; issue_valid = 1'b0; x = '0; y = '0; z = '0; imm = '0; aluc = '0; s2 = '0;
    reg_we = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; en = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_P", P, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", issue_ready, 1);

    // Immediate moves and writeback latency
    mov_imm(4'd1, 16'd5);
    chk("t1_busy_exec", busy, 1);
    mov_imm(4'd2, 16'd7);
    @(negedge clk);
    chk("t1_busy_done", busy, 0);
    chk("t1_P", P, 0);
    read_reg(4'd1);
    read_reg(4'd2);

    // Back-to-back dependent ALU ops through the bypass
    chk("t2_ready0", issue_ready, 1);
    issue(4'd3, 4'd1, 4'd2, 16'h0, 4'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t2_ready1", issue_ready, 1);
    issue(4'd4, 4'd3, 4'd1, 16'h0, 4'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t2_ready2", issue_ready, 1);
    wait_idle();
    read_reg(4'd3);
    read_reg(4'd4);

    // Store with delayed ack, then single-cycle load
    mov_imm(4'd5, 16'h00AB);
    mov_imm(4'd6, 16'h0010);
    mem_op("t3_st", 4'd5, 4'd6, 1'b0, 1'b0, 2'd3, 1'b1, 3, 16'h0);
    mem_op("t4_ld", 4'd7, 4'd6, 1'b1, 1'b1, 2'd1, 1'b1, 0, 16'hBEEF);
    read_reg(4'd7);

    // Squashed lane, then predicate ops
    issue(4'd5, 4'd1, 4'd2, 16'h0, 4'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    mem_op("t5_sq_st", 4'd5, 4'd6, 1'b0, 1'b0, 2'd3, 1'b0, 0, 16'h0);
    read_reg(4'd5);
    mov_imm(4'd8, 16'd3);
    mov_imm(4'd9, 16'd4);
    issue(4'd0, 4'd8, 4'd9, 16'h0, 4'd7, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_idle();
    chk("t5_slt_P", P, mp);
    issue(4'd0, 4'd8, 4'd9, 16'h0, 4'd8, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_idle();
    chk("t5_seq_P", P, mp);

    // Lane constants and multiply
    issue(4'd10, 4'd0, 4'd0, 16'h0, 4'd10, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(4'd11, 4'd0, 4'd0, 16'h0, 4'd11, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    mov_imm(4'd12, 16'hFFFF);
    mov_imm(4'd13, 16'd2);
    issue(4'd14, 4'd12, 4'd13, 16'h0, 4'd12, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    read_reg(4'd10);
    read_reg(4'd11);
    read_reg(4'd14);

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        mem_op("rnd_mem", 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
               2'($urandom), ($urandom_range(0, 4) != 0), $urandom_range(0, 3), 16'($urandom));
      end else begin
        issue(4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom), 4'($urandom),
              2'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0, 1'b0, ($urandom_range(0, 4) != 0));
        if ($urandom_range(0, 1) == 0) begin
          wait_idle();
          chk("rnd_P", P, mp);
        end
      end
    end
    wait_idle();
    chk("rnd_P_end", P, mp);
    for (int r = 0; r < NR; r++) read_reg(4'(r));

    // Reset while a load waits in MEM
    ack_delay = 1000;
    mem_rdata = 16'h1234;
    issue(4'd3, 4'd6, 4'd0, 16'h0, 4'd0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    begin
      int n = 0;
      while (!mem_req && n < 20) begin @(negedge clk); n++; end
      chk("t6_req_up", mem_req, 1);
    end
    reset = 1'b1;
    #1;
    chk("t6_rst_req", mem_req, 0);
    chk("t6_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NR; i++) mr[i] = '0;
    mp = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    chk("t6_P", P, mp);
    read_reg(4'd3);
    read_reg(4'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sp_core_pipe.md
Name: sp_core_pipe

Overview:
Parametrised next-generation streaming-processor lane for the SM core: register file, ALU, writeback select and predicate flag, generalised in data width and register count. It adds a valid/ready instruction issue handshake, a registered execute stage with result bypass, and a req/ack memory port with stall. The per-lane enable squashes instructions instead of gating the clock, so all lanes of an SM stay in lockstep.

Parameters:
CORE_ID, 0, lane index; value returned by the CID op
N_CORES, 1, lanes per SM; value returned by the NCR op
DATA_W, 16, register, ALU and memory data width
N_REGS, 16, register count; REG_AW = clog2(N_REGS), minimum 1
ADDR_W, 16, memory address width; low ADDR_W bits of the operand are used, zero-extended if DATA_W < ADDR_W

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
issue_valid  in  1  instruction present
issue_ready  out  1  lane can accept; transfer occurs when valid && ready
x  in  REG_AW  destination register; also store-data source
y  in  REG_AW  source B; also memory address source
z  in  REG_AW  source C
imm  in  DATA_W  immediate
aluc  in  4  ALU opcode
s2  in  2  writeback select: 0 imm, 1 memory load, 2 ALU, 3 no write
reg_we  in  1  register write enable
mem_rd  in  1  load instruction
mem_wr  in  1  store instruction (mem_rd && mem_wr: treat as store)
en  in  1  lane enable, sampled at issue
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = store
mem_addr  out  ADDR_W  R[y]
mem_wdata  out  DATA_W  R[x]
mem_ack  in  1  request complete; rdata valid for loads
mem_rdata  in  DATA_W  load data
P  out  1  predicate flag
busy  out  1  state != IDLE

Behaviour:
- Reset: all registers 0, P=0, state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0. Reset mid-transaction drops it immediately, with no writeback.
- States: IDLE, EXEC, MEM.
- issue_ready = (IDLE) || (EXEC && the in-flight op is not a memory op). It is 0 in MEM.
- Accept at edge N: latch decode and operands B=R[y], C=R[z], S=R[x]. Bypass: if EXEC writes register r at the same edge, reads of r return the new value.
- ALU op (no mem_rd/mem_wr): EXEC for one cycle. At edge N+1, if reg_we && s2!=3, R[x] <= select(imm, ALU). s2=1 without a memory op writes 0. Next state is EXEC if a new instruction is accepted at N+1, otherwise IDLE.
- Memory op: at edge N+1 enter MEM, set mem_req=1, and register mem_addr/mem_we/mem_wdata. These are held stable until the first edge with mem_ack=1. At that edge: mem_req<=0; a load with reg_we && s2==1 writes R[x] <= mem_rdata; go to IDLE. mem_ack when mem_req=0 is ignored.
- ALU ops, unsigned and modulo 2^DATA_W:
  - 0 ADD B+C; 1 SUB B-C; 2 AND; 3 OR; 4 XOR
  - 5 SHL B<<C[clog2(DATA_W)-1:0]; 6 SHR logical, same shift amount
  - 7 SLT: result 0, P <= (B<C)
  - 8 SEQ: result 0, P <= (B==C)
  - 9 MOV: result B
  - 10 CID: result CORE_ID; 11 NCR: result N_CORES
  - 12 MUL: low DATA_W bits of B*C (see optional feature)
  - 13-15: result 0
- P changes only on an executed SLT/SEQ, at the EXEC edge.
- en=0 at accept: handshake completes and the instruction occupies EXEC for one cycle, but there is no register write, no P update and no memory request. It never enters MEM.
- Writes to the same register from back-to-back instructions: the later one wins, and each sees the earlier one through the bypass.

Optional Feature:
SP_CORE_PIPE_MUL_EN: defined, op 12 is a single-cycle DATA_W x DATA_W multiply returning the low half. Undefined, no multiplier is synthesised and op 12 returns 0 like the reserved ops.

Test Plan:
1. Reset, then issue MOV-imm R1=5 (s2=0) and R2=7 -> after 2 more edges R1=5, R2=7, busy=0, P=0.
2. Back-to-back ADD R3=R1+R2, then SUB R4=R3-R1 on consecutive cycles -> bypass gives R3=12, R4=7, and issue_ready stays 1 throughout.
3. Store R[x]=0x00AB to address R[y]=0x0010, ack delayed 3 cycles -> mem_req=1, mem_we=1, addr/wdata held for 3 cycles, issue_ready=0 until ack; then IDLE.
4. Load from 0x0010 with mem_rdata=0xBEEF, ack on the first cycle -> R[x]=0xBEEF, exactly one request cycle.
5. en=0 with ADD R5 and a store -> no R5 change and mem_req never rises; with en=1, SLT 3<4 -> P=1, then SEQ 3,4 -> P=0.
6. CID/NCR with CORE_ID=3, N_CORES=8 -> 3, 8. MUL 0xFFFF*2 (DATA_W=16) -> 0xFFFE with SP_CORE_PIPE_MUL_EN defined, 0 without. Assert reset during MEM -> mem_req=0 and no write.
